// File: rtl/exu_mem_seq.sv
// Memory-access sequencer between decode and writeback: issues one valid/ready
// bus request per load/store, waits for the response (or a timeout), then holds the result for writeback.
module exu_mem_seq #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_is_load,
    input  logic              i_is_store,
    input  logic [1:0]        i_size,
    input  logic [DATA_W-1:0] i_alu_res,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_wmask,
    input  logic              i_mem_rsp_valid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_rsp_err,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_wb_err,
    output logic              o_busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        WB       = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_load;
    logic                r_mem_req_valid;
    logic [DATA_W-1:0]   r_mem_addr;
    logic                r_mem_wen;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [3:0]          r_mem_wmask;
    logic                r_wb_valid;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_wb_err;

    logic                w_accept;
    logic                w_is_mem;
    logic                w_fault;
    logic                w_timeout;
    logic [3:0]          w_wmask;
    logic [DATA_W-1:0]   w_wdata;

    assign w_accept  = i_valid && o_ready;
    assign w_is_mem  = i_is_load || i_is_store;
    assign w_fault   = (i_size == 2'd3)
                    || (i_size == 2'd1 && i_alu_res[0])
                    || (i_size == 2'd2 && i_alu_res[1:0] != 2'b00);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_wmask = 4'b0000;
        case (i_size)
            2'd0:    w_wmask = 4'b0001 << i_alu_res[1:0];
            2'd1:    w_wmask = 4'b0011 << i_alu_res[1:0];
            2'd2:    w_wmask = 4'b1111;
            default: w_wmask = 4'b0000;
        endcase
    end

    // Each byte lane picks the byte/half/word source so narrow stores land on every lane.
    generate
        for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
            always_comb begin
                case (i_size)
                    2'd0:    w_wdata[gi*8 +: 8] = i_store_data[7:0];
                    2'd1:    w_wdata[gi*8 +: 8] = i_store_data[(gi % 2)*8 +: 8];
                    default: w_wdata[gi*8 +: 8] = i_store_data[gi*8 +: 8];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mem && !w_fault) w_state_next = MEM_REQ;
                    else                      w_state_next = WB;
                end
            end
            MEM_REQ:  if (i_mem_req_ready) w_state_next = MEM_WAIT;
            MEM_WAIT: if (i_mem_rsp_valid || w_timeout) w_state_next = WB;
            WB:       if (i_wb_ready) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == IDLE) && !i_rst;
        o_busy  = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt           <= '0;
            r_is_load       <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= 4'b0000;
            r_wb_valid      <= 1'b0;
            r_wb_data       <= '0;
            r_wb_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= i_alu_res;
                            r_wb_err   <= 1'b0;
                        end else if (w_fault) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= '0;
                            r_wb_err   <= 1'b1;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= i_alu_res;
                            r_mem_wen       <= i_is_store;
                            r_mem_wdata     <= i_is_store ? w_wdata : '0;
                            r_mem_wmask     <= i_is_store ? w_wmask : 4'b0000;
                            r_is_load       <= i_is_load;
                        end
                    end
                end
                MEM_REQ: begin
                    if (i_mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                    end
                end
                MEM_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_mem_rsp_valid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= r_is_load ? i_mem_rdata : '0;
                        r_wb_err   <= i_mem_rsp_err;
                    end else if (w_timeout) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= '0;
                        r_wb_err   <= 1'b1;
                    end
                end
                WB: begin
                    if (i_wb_ready) r_wb_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_req_valid = r_mem_req_valid;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wen       = r_mem_wen;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_mem_wmask     = r_mem_wmask;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_data       = r_wb_data;
    assign o_wb_err        = r_wb_err;

endmodule

// File: tb/tb_exu_mem_seq.sv
// Directed bench for exu_mem_seq with a short timeout; inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_exu_mem_seq;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_is_load;
    logic        i_is_store;
    logic [1:0]  i_size;
    logic [31:0] i_alu_res;
    logic [31:0] i_store_data;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rdata;
    logic        i_mem_rsp_err;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [31:0] o_wb_data;
    logic        o_wb_err;
    logic        o_busy;

    int n_pass;
    int n_total;

    exu_mem_seq #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_is_load       (i_is_load),
        .i_is_store      (i_is_store),
        .i_size          (i_size),
        .i_alu_res       (i_alu_res),
        .i_store_data    (i_store_data),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wen       (o_mem_wen),
        .o_mem_wdata     (o_mem_wdata),
        .o_mem_wmask     (o_mem_wmask),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rdata     (i_mem_rdata),
        .i_mem_rsp_err   (i_mem_rsp_err),
        .o_wb_valid      (o_wb_valid),
        .i_wb_ready      (i_wb_ready),
        .o_wb_data       (o_wb_data),
        .o_wb_err        (o_wb_err),
        .o_busy          (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] sd);
        i_valid      = 1'b1;
        i_is_load    = ld;
        i_is_store   = st;
        i_size       = sz;
        i_alu_res    = addr;
        i_store_data = sd;
        tick();
        i_valid    = 1'b0;
        i_is_load  = 1'b0;
        i_is_store = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        i_rst = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        i_size = 2'd0; i_alu_res = '0; i_store_data = '0; i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0; i_mem_rdata = '0; i_mem_rsp_err = 1'b0; i_wb_ready = 1'b1;
        tick(); tick();
        chk("rst_ready", o_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_wb_valid", o_wb_valid, 0);
        chk("rst_req_valid", o_mem_req_valid, 0);
        i_rst = 1'b0;
        tick();
        chk("idle_ready", o_ready, 1);

        // ALU pass-through
        issue(1'b0, 1'b0, 2'd2, 32'h1234_5678, 32'h0);
        chk("alu_wb_valid", o_wb_valid, 1);
        chk("alu_wb_data", o_wb_data, 32'h1234_5678);
        chk("alu_wb_err", o_wb_err, 0);
        chk("alu_ready_low", o_ready, 0);
        tick();
        chk("alu_wb_drop", o_wb_valid, 0);
        chk("alu_ready_back", o_ready, 1);

        // Word load with 3 cycles of request stall
        issue(1'b1, 1'b0, 2'd2, 32'h8000_0004, 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk("ld_req_valid", o_mem_req_valid, 1);
            chk("ld_req_addr", o_mem_addr, 32'h8000_0004);
            if (c == 3) i_mem_req_ready = 1'b1;
            else tick();
        end
        chk("ld_wen", o_mem_wen, 0);
        chk("ld_wmask", o_mem_wmask, 4'b0000);
        tick();
        i_mem_req_ready = 1'b0;
        chk("ld_req_done", o_mem_req_valid, 0);
        chk("ld_wait_busy", o_busy, 1);
        tick();
        chk("ld_wait_no_wb", o_wb_valid, 0);
        i_mem_rsp_valid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        tick();
        i_mem_rsp_valid = 1'b0;
        chk("ld_wb_valid", o_wb_valid, 1);
        chk("ld_wb_data", o_wb_data, 32'hDEAD_BEEF);
        chk("ld_wb_err", o_wb_err, 0);
        tick();
        chk("ld_wb_drop", o_wb_valid, 0);

        // Byte store to lane 3
        issue(1'b0, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB);
        chk("sb_req_valid", o_mem_req_valid, 1);
        chk("sb_wen", o_mem_wen, 1);
        chk("sb_wmask", o_mem_wmask, 4'b1000);
        chk("sb_wdata", o_mem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", o_mem_addr, 32'h8000_0003);
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b1; i_mem_rdata = 32'h5555_5555;
        tick();
        i_mem_rsp_valid = 1'b0;
        chk("sb_wb_valid", o_wb_valid, 1);
        chk("sb_wb_data", o_wb_data, 32'h0);
        chk("sb_wb_err", o_wb_err, 0);
        tick();

        // Half store, upper half
        issue(1'b0, 1'b1, 2'd1, 32'h0000_0002, 32'hFFFF_1234);
        chk("sh_wmask", o_mem_wmask, 4'b1100);
        chk("sh_wdata", o_mem_wdata, 32'h1234_1234);
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b1;
        tick();
        i_mem_rsp_valid = 1'b0;
        chk("sh_wb_valid", o_wb_valid, 1);
        tick();

        // Faulting accesses never reach the bus
        issue(1'b1, 1'b0, 2'd1, 32'h0000_1001, 32'h0);
        chk("mis_h_req", o_mem_req_valid, 0);
        chk("mis_h_wb_valid", o_wb_valid, 1);
        chk("mis_h_err", o_wb_err, 1);
        chk("mis_h_data", o_wb_data, 32'h0);
        tick();
        issue(1'b0, 1'b1, 2'd2, 32'h0000_1002, 32'h0);
        chk("mis_w_req", o_mem_req_valid, 0);
        chk("mis_w_wb_valid", o_wb_valid, 1);
        chk("mis_w_err", o_wb_err, 1);
        tick();
        issue(1'b1, 1'b0, 2'd3, 32'h0000_0000, 32'h0);
        chk("size3_req", o_mem_req_valid, 0);
        chk("size3_wb_valid", o_wb_valid, 1);
        chk("size3_err", o_wb_err, 1);
        tick();

        // Timeout: 4 cycles in MEM_WAIT without response
        issue(1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tick();
            chk("to_not_yet", o_wb_valid, 0);
        end
        tick();
        chk("to_wb_valid", o_wb_valid, 1);
        chk("to_err", o_wb_err, 1);
        chk("to_data", o_wb_data, 32'h0);
        i_wb_ready = 1'b0;
        i_mem_rsp_valid = 1'b1; i_mem_rdata = 32'h0000_FFFF;
        tick();
        chk("stray_wb_data", o_wb_data, 32'h0);
        chk("stray_wb_valid", o_wb_valid, 1);
        i_wb_ready = 1'b1;
        tick();
        chk("stray_idle_busy", o_busy, 0);
        tick();
        i_mem_rsp_valid = 1'b0;
        chk("stray_idle_wb", o_wb_valid, 0);

        // Bus error on a load keeps the read data
        issue(1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'h0);
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b1; i_mem_rsp_err = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
        tick();
        i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0;
        chk("berr_data", o_wb_data, 32'hCAFE_F00D);
        chk("berr_err", o_wb_err, 1);
        tick();

        // Writeback backpressure for 5 cycles
        i_wb_ready = 1'b0;
        issue(1'b0, 1'b0, 2'd0, 32'hA5A5_A5A5, 32'h0);
        i_valid = 1'b1; i_alu_res = 32'h1111_1111;
        for (int c = 0; c < 5; c++) begin
            chk("bp_wb_valid", o_wb_valid, 1);
            chk("bp_wb_data", o_wb_data, 32'hA5A5_A5A5);
            chk("bp_ready", o_ready, 0);
            tick();
        end
        i_valid = 1'b0;
        i_wb_ready = 1'b1;
        tick();
        chk("bp_wb_drop", o_wb_valid, 0);

        // Reset while waiting for a response
        issue(1'b1, 1'b0, 2'd2, 32'h0000_0030, 32'h0);
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        chk("rw_in_wait", o_busy, 1);
        i_rst = 1'b1;
        tick();
        chk("rw_busy", o_busy, 0);
        chk("rw_req_valid", o_mem_req_valid, 0);
        chk("rw_addr", o_mem_addr, 32'h0);
        chk("rw_wb_valid", o_wb_valid, 0);
        chk("rw_wb_data", o_wb_data, 32'h0);
        chk("rw_wb_err", o_wb_err, 0);
        chk("rw_ready_in_rst", o_ready, 0);
        i_rst = 1'b0;
        #1;
        chk("rw_ready_after", o_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
